ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Upstream stage of the tic-tac-toe board logic.
- Receives raw PS/2 keyboard traffic (scan code set 2) from the board's PS/2 pins and turns make-codes for digits 1-9 into single-cycle pulses on key_1..key_9.
- square_status consumes those pulses directly.
- Handles break/extended prefixes, framing/parity errors and stalled frames, so downstream sees exactly one pulse per key press.

Parameters:
- GLITCH_CYCLES, 4: consecutive identical samples required before filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 100000: clk cycles without a ps2_clk falling edge that abort a partial frame (2 ms at 50 MHz).
- TO_W, 17: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (50 MHz).
- clr  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk.
- key_1 .. key_9  out  1 each  one-clk pulse on a make-code for that digit.
- last_code  out  8  last valid received byte, held.
- frame_err  out  1  one-clk pulse on start/parity/stop error or timeout.

Behaviour:
- Reset: clr low asynchronously clears every register; all outputs 0; FSM in IDLE; prefix flags cleared. Deassertion is synchronised internally with a 2-flop release.
- Input conditioning: ps2_clk and ps2_data each pass through 2 sync flops. Synchronised ps2_clk goes through a saturating glitch filter: filtered level flips only after GLITCH_CYCLES equal samples. fall_edge = filtered 1->0, one clk wide. ps2_data is sampled on fall_edge.
- Frame FSM:
  - IDLE: fall_edge with data=0 -> RECV, bit_cnt=0. fall_edge with data=1 -> stay IDLE, pulse frame_err.
  - RECV: each fall_edge shifts data LSB-first into an 8-bit shift register; bit_cnt 0..7, then PARITY.
  - PARITY: fall_edge captures the parity bit -> STOP.
  - STOP: fall_edge captures the stop bit. Good frame = stop=1 and odd parity over data+parity. Good -> byte_valid pulse. Bad -> frame_err pulse. Either way -> IDLE.
  - Timeout: the counter reloads on every fall_edge and counts only outside IDLE. Reaching TIMEOUT_CYCLES -> IDLE, frame_err pulse, shift register discarded.
- Decode, on byte_valid only:
  - last_code <= byte.
  - 0xF0: set brk.
  - 0xE0: set ext.
  - Any other byte: if brk=0 and ext=0 and the byte is a digit code, pulse the matching key; then clear brk and ext.
  - frame_err also clears brk and ext.
- Digit codes:
  - Main row 1..9 = 16 1E 26 25 2E 36 3D 3E 46.
  - Keypad 1..9 = 69 72 7A 6B 73 74 6C 75 7D.
  - Unmapped codes produce no pulse.
- Outputs: at most one key_n is high in any cycle. Pulses are exactly 1 clk.
- Latency: key_n rises exactly 2 clk after the fall_edge cycle of the stop bit (byte_valid registered +1, key register +1). frame_err rises 1 clk after the detecting cycle.
- Boundaries:
  - Typematic repeat (make code resent while held) pulses again; square_status rejects occupied squares.
  - E0 followed by F0 followed by code: no pulse, both flags cleared after the code.
  - F0 F0 (noise): second F0 keeps brk set.
  - Reset mid-frame: partial byte lost, no pulse.
  - Timeout and fall_edge in the same cycle: fall_edge wins, counter reloads.

Decomposition:
- Package ps2_pkg holds: scan-code constants (CODE_BREAK=8'hF0, CODE_EXT=8'hE0, the 18 digit codes), FSM state encoding (IDLE, RECV, PARITY, STOP), and a function mapping a byte to a 9-bit one-hot key vector.
- One sub-module, ps2_rx_frame: sync, glitch filter, frame FSM and timeout. It outputs byte_valid, byte[7:0] and frame_err.
- The top handles prefix flags, mapping and output registers.

Test Plan:
- Frame 0x16, valid parity (parity bit 0) -> key_1 single pulse 2 clk after the stop-bit edge; last_code=8'h16; frame_err never high.
- Sequence 0x73, F0, 0x73 -> exactly one key_5 pulse; no pulse for the release.
- Sequence E0, 0x75 (arrow up) -> no key_8 pulse; the following bare 0x75 -> key_8 pulse.
- Frame 0x3D with corrupted parity -> frame_err pulse, no key_7; the next clean 0x3D -> key_7 pulse.
- Send 5 bits then stall ps2_clk high for 100000 clk -> frame_err pulse, FSM back in IDLE; a full 0x46 frame then -> key_9 pulse.
- Drive clr low mid-frame and 1-clk glitches on ps2_clk -> all outputs 0 immediately; glitches shorter than GLITCH_CYCLES produce no shifted bits.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end: scan-code set 2 constants,
// receive FSM encoding and the digit-to-key mapping.
package ps2_pkg;

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;

  localparam logic [7:0] CODE_MAIN_1 = 8'h16;
  localparam logic [7:0] CODE_MAIN_2 = 8'h1E;
  localparam logic [7:0] CODE_MAIN_3 = 8'h26;
  localparam logic [7:0] CODE_MAIN_4 = 8'h25;
  localparam logic [7:0] CODE_MAIN_5 = 8'h2E;
  localparam logic [7:0] CODE_MAIN_6 = 8'h36;
  localparam logic [7:0] CODE_MAIN_7 = 8'h3D;
  localparam logic [7:0] CODE_MAIN_8 = 8'h3E;
  localparam logic [7:0] CODE_MAIN_9 = 8'h46;

  localparam logic [7:0] CODE_PAD_1  = 8'h69;
  localparam logic [7:0] CODE_PAD_2  = 8'h72;
  localparam logic [7:0] CODE_PAD_3  = 8'h7A;
  localparam logic [7:0] CODE_PAD_4  = 8'h6B;
  localparam logic [7:0] CODE_PAD_5  = 8'h73;
  localparam logic [7:0] CODE_PAD_6  = 8'h74;
  localparam logic [7:0] CODE_PAD_7  = 8'h6C;
  localparam logic [7:0] CODE_PAD_8  = 8'h75;
  localparam logic [7:0] CODE_PAD_9  = 8'h7D;

  typedef enum logic [1:0] {IDLE, RECV, PARITY, STOP} rx_state_e;

  // Bit n-1 of the result corresponds to key n; unmapped codes give all zeros.
  function automatic logic [8:0] key_onehot(input logic [7:0] code);
    key_onehot = '0;
    case (code)
      CODE_MAIN_1, CODE_PAD_1: key_onehot = 9'b0_0000_0001;
      CODE_MAIN_2, CODE_PAD_2: key_onehot = 9'b0_0000_0010;
      CODE_MAIN_3, CODE_PAD_3: key_onehot = 9'b0_0000_0100;
      CODE_MAIN_4, CODE_PAD_4: key_onehot = 9'b0_0000_1000;
      CODE_MAIN_5, CODE_PAD_5: key_onehot = 9'b0_0001_0000;
      CODE_MAIN_6, CODE_PAD_6: key_onehot = 9'b0_0010_0000;
      CODE_MAIN_7, CODE_PAD_7: key_onehot = 9'b0_0100_0000;
      CODE_MAIN_8, CODE_PAD_8: key_onehot = 9'b0_1000_0000;
      CODE_MAIN_9, CODE_PAD_9: key_onehot = 9'b1_0000_0000;
      default:                 key_onehot = '0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronisers, ps2_clk glitch filter, 11-bit frame FSM
// and stalled-frame timeout. Emits one-cycle byte_valid / frame_err pulses.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int GLITCH_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);

  localparam int GW = $clog2(GLITCH_CYCLES + 1);

  logic [1:0]      clk_sync_q, data_sync_q;
  logic [GW-1:0]   glitch_cnt_q, glitch_cnt_d;
  logic            filt_q, filt_d;
  logic            fall_edge, rx_bit;
  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= '0;
      data_sync_q  <= '0;
      glitch_cnt_q <= '0;
      filt_q       <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q  <= {data_sync_q[0], ps2_data_i};
      glitch_cnt_q <= glitch_cnt_d;
      filt_q       <= filt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Any sample matching the filtered level restarts the run of disagreeing samples.
  always_comb begin
    filt_d       = filt_q;
    glitch_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (glitch_cnt_q == GW'(GLITCH_CYCLES - 1)) filt_d = clk_sync_q[1];
      else glitch_cnt_d = glitch_cnt_q + GW'(1);
    end
  end

  assign fall_edge = filt_q & ~filt_d;
  assign rx_bit    = data_sync_q[1];

  // A falling edge always takes priority over the timeout and reloads the counter.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    to_cnt_d     = to_cnt_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall_edge) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!rx_bit) begin
            state_d   = RECV;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        RECV: begin
          shift_d   = {rx_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = rx_bit;
          state_d  = STOP;
        end
        STOP: begin
          if (rx_bit && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
          else frame_err_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d     = IDLE;
        frame_err_d = 1'b1;
        shift_d     = '0;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = shift_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the tic-tac-toe board: turns make-codes for digits
// 1-9 (main row or keypad) into one-clock pulses, ignoring break and extended keys.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int GLITCH_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_1,
  output logic       key_2,
  output logic       key_3,
  output logic       key_4,
  output logic       key_5,
  output logic       key_6,
  output logic       key_7,
  output logic       key_8,
  output logic       key_9,
  output logic [7:0] last_code,
  output logic       frame_err
);

  logic [1:0] rst_sync_q;
  logic       rst_n;
  logic       byte_valid, rx_err;
  logic [7:0] rx_byte;
  logic       brk_q, brk_d, ext_q, ext_d;
  logic [8:0] key_q, key_d;
  logic [7:0] last_code_q, last_code_d;

  // Reset asserts immediately but is released only after two clean clk edges.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  ps2_rx_frame #(
    .GLITCH_CYCLES (GLITCH_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .byte_valid_o(byte_valid),
    .byte_o      (rx_byte),
    .frame_err_o (rx_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_q       <= '0;
      last_code_q <= '0;
    end else begin
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      key_q       <= key_d;
      last_code_q <= last_code_d;
    end
  end

  // Prefixes accumulate until the next ordinary code, which consumes and clears them.
  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    key_d       = '0;
    last_code_d = last_code_q;
    if (byte_valid) begin
      last_code_d = rx_byte;
      if (rx_byte == CODE_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == CODE_EXT) begin
        ext_d = 1'b1;
      end else begin
        if (!brk_q && !ext_q) key_d = key_onehot(rx_byte);
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end else if (rx_err) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end
  end

  assign {key_9, key_8, key_7, key_6, key_5, key_4, key_3, key_2, key_1} = key_q;
  assign last_code = last_code_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of PS/2 frames with expected key pulses,
// plus hand-written timeout, glitch and mid-frame reset sequences.
module tb_ps2_key_decoder;

  localparam int GLITCH  = 4;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 20;
  localparam int KEY_LAT = 7;

  typedef struct {
    logic [7:0] code;
    bit         badPar;
    bit         badStop;
    int         expKey;
    bit         expErr;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_1, key_2, key_3, key_4, key_5, key_6, key_7, key_8, key_9;
  logic [7:0] last_code;
  logic       frame_err;

  int nCompare = 0;
  int nFail = 0;
  int cyc = 0;
  int lastFallCyc = 0;
  int pulseCnt[9];
  int errCnt = 0;
  int shapeViol = 0;
  int firstKeyCyc = -1;
  int firstErrCyc = -1;
  logic [8:0] keysNow;
  logic [8:0] keysPrev = '0;
  logic       errPrev = 1'b0;
  logic [7:0] expLast = 8'h00;
  vec_t       vecs[$];

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .GLITCH_CYCLES (GLITCH),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TO_W          (11)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_1    (key_1),
    .key_2    (key_2),
    .key_3    (key_3),
    .key_4    (key_4),
    .key_5    (key_5),
    .key_6    (key_6),
    .key_7    (key_7),
    .key_8    (key_8),
    .key_9    (key_9),
    .last_code(last_code),
    .frame_err(frame_err)
  );

  assign keysNow = {key_9, key_8, key_7, key_6, key_5, key_4, key_3, key_2, key_1};

  always @(posedge clk) cyc++;

  // Counts pulses and flags any multi-key cycle or pulse wider than one clock.
  always @(negedge clk) begin
    for (int k = 0; k < 9; k++)
      if (keysNow[k] && !keysPrev[k]) pulseCnt[k]++;
    if ((keysNow & keysPrev) != 9'd0) shapeViol++;
    if ($countones(keysNow) > 1) shapeViol++;
    if (frame_err && !errPrev) errCnt++;
    if (frame_err && errPrev) shapeViol++;
    if (keysNow != 9'd0 && firstKeyCyc < 0) firstKeyCyc = cyc;
    if (frame_err && firstErrCyc < 0) firstErrCyc = cyc;
    keysPrev = keysNow;
    errPrev  = frame_err;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected under 60000", cyc);
    $fatal(1);
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    nCompare++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] code, input bit badPar,
                                            input bit badStop);
    logic par;
    par = ~(^code) ^ badPar;
    return {~badStop, par, code, 1'b0};
  endfunction

  task automatic clearMon();
    @(negedge clk);
    #1;
    for (int k = 0; k < 9; k++) pulseCnt[k] = 0;
    errCnt      = 0;
    firstKeyCyc = -1;
    firstErrCyc = -1;
  endtask

  // Data is set while ps2_clk is high; optional 3-clock low glitches land mid high phase.
  task automatic sendBits(input logic [10:0] frame, input int n, input bit glitchy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = frame[i];
      if (glitchy) begin
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (GLITCH - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 5 - (GLITCH - 1)) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      lastFallCyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
  endtask

  function automatic logic [8:0] keyMask(input int key);
    logic [8:0] m;
    m = '0;
    if (key > 0) m[key-1] = 1'b1;
    return m;
  endfunction

  function automatic int totalPulses();
    int t;
    t = 0;
    for (int k = 0; k < 9; k++) t += pulseCnt[k];
    return t;
  endfunction

  function automatic logic [8:0] seenMask();
    logic [8:0] m;
    m = '0;
    for (int k = 0; k < 9; k++) m[k] = (pulseCnt[k] != 0);
    return m;
  endfunction

  task automatic applyStimulus(input string name, input vec_t v, input bit glitchy);
    clearMon();
    sendBits(makeFrame(v.code, v.badPar, v.badStop), 11, glitchy);
    repeat (30) @(negedge clk);
    if (!v.badPar && !v.badStop) expLast = v.code;
    checkOutput({name, " keys"}, seenMask(), keyMask(v.expKey));
    checkOutput({name, " pulses"}, totalPulses(), (v.expKey > 0) ? 1 : 0);
    checkOutput({name, " frame_err"}, errCnt, v.expErr ? 1 : 0);
    checkOutput({name, " last_code"}, last_code, expLast);
    if (v.expKey > 0)
      checkOutput({name, " key latency"}, firstKeyCyc - lastFallCyc, KEY_LAT);
  endtask

  initial begin
    vecs.push_back('{8'h16, 1'b0, 1'b0, 1, 1'b0});
    vecs.push_back('{8'h16, 1'b0, 1'b0, 1, 1'b0});
    vecs.push_back('{8'h73, 1'b0, 1'b0, 5, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h73, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 8, 1'b0});
    vecs.push_back('{8'h3D, 1'b1, 1'b0, 0, 1'b1});
    vecs.push_back('{8'h3D, 1'b0, 1'b0, 7, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h26, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h26, 1'b0, 1'b0, 3, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h69, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h69, 1'b0, 1'b0, 1, 1'b0});
    vecs.push_back('{8'h2E, 1'b0, 1'b1, 0, 1'b1});
    vecs.push_back('{8'h7D, 1'b0, 1'b0, 9, 1'b0});
    vecs.push_back('{8'h1C, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h3E, 1'b0, 1'b0, 8, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h16, 1'b1, 1'b0, 0, 1'b1});
    vecs.push_back('{8'h16, 1'b0, 1'b0, 1, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{8'h46, 1'b0, 1'b1, 0, 1'b1});
    vecs.push_back('{8'h46, 1'b0, 1'b0, 9, 1'b0});
    vecs.push_back('{8'h36, 1'b0, 1'b0, 6, 1'b0});
    vecs.push_back('{8'h25, 1'b0, 1'b0, 4, 1'b0});
    vecs.push_back('{8'h1E, 1'b0, 1'b0, 2, 1'b0});
    vecs.push_back('{8'h6C, 1'b0, 1'b0, 7, 1'b0});
    vecs.push_back('{8'h7A, 1'b0, 1'b0, 3, 1'b0});
    vecs.push_back('{8'h72, 1'b0, 1'b0, 2, 1'b0});
    vecs.push_back('{8'h74, 1'b0, 1'b0, 6, 1'b0});
    vecs.push_back('{8'h6B, 1'b0, 1'b0, 4, 1'b0});
    vecs.push_back('{8'h2E, 1'b0, 1'b0, 5, 1'b0});

    repeat (3) @(negedge clk);
    checkOutput("reset keys", keysNow, 0);
    checkOutput("reset last_code", last_code, 0);
    checkOutput("reset frame_err", frame_err, 0);
    clr = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus($sformatf("vec%0d code %02h", i, vecs[i].code), vecs[i], 1'b0);

    // Stalled frame: five bits then ps2_clk parked high until the timeout fires.
    clearMon();
    sendBits(makeFrame(8'h46, 1'b0, 1'b0), 5, 1'b0);
    for (int w = 0; w < TIMEOUT + 200 && firstErrCyc < 0; w++) @(negedge clk);
    repeat (5) @(negedge clk);
    checkOutput("timeout frame_err", errCnt, 1);
    checkOutput("timeout latency in range",
                (firstErrCyc - lastFallCyc >= TIMEOUT) && (firstErrCyc - lastFallCyc <= TIMEOUT + 8), 1);
    checkOutput("timeout pulses", totalPulses(), 0);
    checkOutput("timeout last_code", last_code, expLast);
    applyStimulus("after timeout 46", '{8'h46, 1'b0, 1'b0, 9, 1'b0}, 1'b0);

    // Short glitches in idle must neither start a frame nor flag a bad start bit.
    clearMon();
    for (int g = 0; g < 6; g++) begin
      ps2_clk = 1'b0;
      repeat ((g % 2 == 0) ? 1 : GLITCH - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (12) @(negedge clk);
    end
    checkOutput("idle glitch frame_err", errCnt, 0);
    checkOutput("idle glitch pulses", totalPulses(), 0);
    applyStimulus("glitchy frame 1E", '{8'h1E, 1'b0, 1'b0, 2, 1'b0}, 1'b1);

    // Reset in the middle of a frame clears outputs at once and loses the partial byte.
    clearMon();
    sendBits(makeFrame(8'h16, 1'b0, 1'b0), 4, 1'b0);
    clr = 1'b0;
    #1;
    checkOutput("mid-frame reset keys", keysNow, 0);
    checkOutput("mid-frame reset last_code", last_code, 0);
    checkOutput("mid-frame reset frame_err", frame_err, 0);
    expLast = 8'h00;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("post-reset pulses", totalPulses(), 0);
    checkOutput("post-reset frame_err", errCnt, 0);
    applyStimulus("post-reset 16", '{8'h16, 1'b0, 1'b0, 1, 1'b0}, 1'b0);

    checkOutput("pulse shape violations", shapeViol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nCompare, nFail);
    $finish;
  end

endmodule
